demux16_rr_sched: RTL and testbench
===================================

Name: demux16_rr_sched

Overview:
- Round-robin scheduler that shares the single-bit In line of the 16-way demux (demux16) between 16 requesters.
- Arbitrates Req[15:0], then drives the demux's Choice and In so the winner's Out line is asserted for a bounded burst.
- Guarantees at least one idle cycle between consecutive bursts so demux outputs never glitch between channels.
- Sits directly in front of demux16; Choice/In connect one-to-one to its inputs.

Parameters:
- HOLD_CYCLES, 4, burst length in cycles per grant; legal range 1..255.
- CNT_W, 8, width of the internal burst counter; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  1 = new grants allowed; 0 = no new grant starts, a running burst completes.
- Req  input  16  request per channel; level-sensitive, held by the requester until served.
- Choice  output  4  channel select to the demux; registered.
- In  output  1  demux data/enable; 1 while a burst is active; registered.
- Busy  output  1  1 while in GRANT state; registered.
- Last  output  4  index of the most recently granted channel; registered.

Behaviour:
- Reset (async, while Reset=1): state=IDLE, Choice=0, In=0, Busy=0, Last=15, counter=0. Last=15 makes channel 0 highest priority after reset.
- Reset mid-burst: In drops to 0 immediately (asynchronous); no partial burst resumes after release.
- Two-state FSM: IDLE, GRANT.
- IDLE: In=0, Busy=0, Choice holds its previous value.
  - Arbitration on the rising edge when Enable=1 and Req!=0.
  - Search order is (Last+1) mod 16, (Last+2) mod 16, ..., Last; first asserted Req wins (index k).
  - Next cycle: state=GRANT, Choice=k, Last=k, In=1, Busy=1, counter=1.
  - Latency: Req sampled at edge t gives In=1 from edge t+1.
- GRANT: Choice is stable for the whole burst.
  - Each edge where Req[Choice]=1 and counter<HOLD_CYCLES: counter increments, In stays 1.
  - Each edge where counter==HOLD_CYCLES: return to IDLE, In=0, Busy=0.
  - Each edge where Req[Choice]=0: early release; return to IDLE, In=0, Busy=0, regardless of counter.
  - Full burst is exactly HOLD_CYCLES cycles of In=1.
- Gap: every return to IDLE spends at least 1 cycle with In=0. The earliest next burst starts 2 edges after the last In=1 cycle.
- Wrap-around: the priority search wraps modulo 16, so Last=15 searches starting at 0.
- Single requester: a channel with Req held continuously gets repeated bursts separated by 1 idle cycle.
- Enable=0 during GRANT: the burst finishes normally; no new grant while Enable=0.
- Simultaneous release and expiry (Req drop on the final count): same result, IDLE next cycle.
- Req changes on other channels during GRANT are ignored until the next IDLE arbitration.
- No output is combinational from inputs.

Test Plan:
- Reset: assert Reset mid-burst -> In=0, Busy=0, Choice=0, Last=15 asynchronously. After release with Req=16'h0001 -> Choice=0, In=1 one edge later.
- Single channel, HOLD_CYCLES=4: Req=16'h0020 held -> In pattern 1,1,1,1,0 repeating, Choice=5 throughout, Last=5.
- Round-robin, HOLD_CYCLES=2: Req=16'h8003 held from reset -> grant order 0,1,15,0,1,... Each burst is 2 cycles with a 1-cycle gap.
- Early release: Req[3] drops after 1 cycle of a 4-cycle burst -> In=0 on the next edge, Busy=0. The next requester is granted 1 cycle later.
- Enable gating: Enable=0 while Req=16'hFFFF -> In stays 0. Enable dropped mid-burst -> burst completes and no further grant.
- Wrap-around: Last=14 with Req=16'h4001 -> grant channel 0 next, then channel 14.

Source files
------------

// File: rtl/demux16_rr_sched.sv
// demux16_rr_sched: round-robin scheduler that grants one of 16 requesters a bounded burst on the demux16 In line
// Ports: i_clk/i_rst (async, active-high), i_enable gates new grants, i_req per-channel level requests;
//        o_choice demux select, o_in demux data, o_busy grant active, o_last most recently granted channel.
module demux16_rr_sched #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic [15:0] i_req,
  output logic [3:0]  o_choice,
  output logic        o_in,
  output logic        o_busy,
  output logic [3:0]  o_last
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [CNT_W-1:0] HOLD = CNT_W'(HOLD_CYCLES);
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0] w_win, w_idx;
  logic w_found, w_start, w_done;
  // search downward so the channel closest after o_last overwrites the rest and wins
  always_comb begin
    w_win = '0;
    w_found = 1'b0;
    w_idx = '0;
    for (int i = 16; i >= 1; i--) begin
      w_idx = o_last + 4'(i);
      w_win = i_req[w_idx] ? w_idx : w_win;
      w_found = w_found | i_req[w_idx];
    end
  end
  assign w_start = i_enable & w_found;
  assign w_done = !i_req[o_choice] || r_cnt == HOLD;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_start ? GRANT : IDLE) : (w_done ? IDLE : GRANT);
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_choice <= '0;
      o_in <= 1'b0;
      o_busy <= 1'b0;
      o_last <= 4'd15;
      r_cnt <= '0;
    end else begin
      o_in <= w_next == GRANT;
      o_busy <= w_next == GRANT;
      if (r_state == IDLE && w_start) begin
        o_choice <= w_win;
        o_last <= w_win;
        r_cnt <= CNT_W'(1);
      end else if (r_state == GRANT) begin
        r_cnt <= w_done ? '0 : r_cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_demux16_rr_sched.sv
// tb_demux16_rr_sched: directed self-checking bench for demux16_rr_sched (HOLD_CYCLES=4 and =2 instances)
module tb_demux16_rr_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b1;
  logic [15:0] req4 = '0, req2 = '0;
  logic [3:0] choice4, last4, choice2, last2;
  logic in4, busy4, in2, busy2;
  int n_checks = 0, n_fail = 0;
  int pat_single[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int pat_en[6] = '{1, 1, 1, 0, 0, 0};
  int rr_in[12] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  int rr_ch[12] = '{0, 0, 0, 1, 1, 1, 15, 15, 15, 0, 0, 0};
  int wr_in[6] = '{1, 1, 1, 1, 0, 1};
  int wr_ch[6] = '{0, 0, 0, 0, 0, 14};
  demux16_rr_sched #(.HOLD_CYCLES(4), .CNT_W(8)) u4 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_req(req4),
    .o_choice(choice4), .o_in(in4), .o_busy(busy4), .o_last(last4));
  demux16_rr_sched #(.HOLD_CYCLES(2), .CNT_W(8)) u2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_req(req2),
    .o_choice(choice2), .o_in(in2), .o_busy(busy2), .o_last(last2));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_choice", 32'(choice4), 0);
    check("rst_in", 32'(in4), 0);
    check("rst_busy", 32'(busy4), 0);
    check("rst_last", 32'(last4), 15);
    step;
    rst = 1'b0;
    req4 = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      step;
      check("single_in", 32'(in4), 32'(pat_single[i]));
      check("single_choice", 32'(choice4), 5);
    end
    check("single_last", 32'(last4), 5);
    req4 = '0;
    step;
    check("idle_in", 32'(in4), 0);
    req4 = 16'h0018;
    step;
    check("er_grant_in", 32'(in4), 1);
    check("er_grant_ch", 32'(choice4), 3);
    req4 = 16'h0010;
    step;
    check("er_release_in", 32'(in4), 0);
    check("er_release_busy", 32'(busy4), 0);
    step;
    check("er_next_in", 32'(in4), 1);
    check("er_next_ch", 32'(choice4), 4);
    check("er_next_last", 32'(last4), 4);
    #2 rst = 1'b1;
    #1;
    check("amid_in", 32'(in4), 0);
    check("amid_busy", 32'(busy4), 0);
    check("amid_choice", 32'(choice4), 0);
    check("amid_last", 32'(last4), 15);
    req4 = 16'h0001;
    step;
    rst = 1'b0;
    step;
    check("post_rst_in", 32'(in4), 1);
    check("post_rst_ch", 32'(choice4), 0);
    en = 1'b0;
    req4 = 16'hFFFF;
    for (int i = 0; i < 6; i++) begin
      step;
      check("en_gate_in", 32'(in4), 32'(pat_en[i]));
    end
    en = 1'b1;
    step;
    check("en_resume_in", 32'(in4), 1);
    check("en_resume_ch", 32'(choice4), 1);
    req4 = 16'h4000;
    step;
    check("wr_drop_in", 32'(in4), 0);
    step;
    check("wr_14_ch", 32'(choice4), 14);
    req4 = 16'h0001;
    step;
    check("wr_gap_in", 32'(in4), 0);
    check("wr_last14", 32'(last4), 14);
    req4 = 16'h4001;
    for (int i = 0; i < 6; i++) begin
      step;
      check("wrap_in", 32'(in4), 32'(wr_in[i]));
      check("wrap_ch", 32'(choice4), 32'(wr_ch[i]));
    end
    rst = 1'b1;
    req2 = 16'h8003;
    #1;
    check("rr_rst_last", 32'(last2), 15);
    step;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step;
      check("rr_in", 32'(in2), 32'(rr_in[i]));
      check("rr_ch", 32'(choice2), 32'(rr_ch[i]));
      check("rr_busy", 32'(busy2), 32'(rr_in[i]));
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
